// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port:
// writebacks are serialised into BEATS beats, reads are reassembled into a line.
module cache_mem_arbiter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int            CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic                         last;
    logic [BEATS-1:0][BEAT_W-1:0] line_buf;
    logic [BEATS-1:0][BEAT_W-1:0] wr_beats;
    logic                         d_req;
    logic                         grant_d;
    logic                         grant_i;
    logic                         unused_addr_bits;

    assign wr_beats         = d_wdata;
    assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};

    // On contention the side that did not win the previous contention goes first.
    assign d_req   = d_read | d_write;
    assign grant_d = d_req & (~i_read | ~last);
    assign grant_i = i_read & ~grant_d;

    assign mem_wdata = (state == D_WR) ? wr_beats[cnt] : '0;
    assign i_rdata   = line_buf;
    assign d_rdata   = line_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            line_buf  <= '0;
            last      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            i_resp    <= 1'b0;
            d_resp    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        mem_addr <= {d_addr[31:5], 5'b0};
                        if (i_read) last <= 1'b1;
                        if (d_write) begin
                            state     <= D_WR;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= D_RD;
                            mem_read <= 1'b1;
                        end
                    end else if (grant_i) begin
                        mem_addr <= {i_addr[31:5], 5'b0};
                        if (d_req) last <= 1'b0;
                        state    <= I_RD;
                        mem_read <= 1'b1;
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (mem_resp) begin
                        if (state != D_WR) line_buf[cnt] <= mem_rdata;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            state     <= DONE;
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
                            i_resp    <= (state == I_RD);
                            d_resp    <= (state != I_RD);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
